// File: rtl/bcd_subtractor_serial_if.sv
// Request/result bundle for the serial BCD subtractor.
interface bcd_subtractor_serial_if #(
  parameter int unsigned DIGITS = 2
) ();
  logic                  start;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  Bin;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   D;
  logic                  Bout;
  logic                  neg;
  logic                  err;

  modport master (
    output start, A, B, Bin,
    input  ready, done, D, Bout, neg, err
  );

  modport slave (
    input  start, A, B, Bin,
    output ready, done, D, Bout, neg, err
  );
endinterface

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor, LSD first, one digit per cycle.
// Define BCD_SUB_SIGN_MAG_EN to add a FIX pass that turns negative results into sign-magnitude.
module bcd_subtractor_serial #(
  parameter int unsigned DIGITS = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  bcd_subtractor_serial_if.slave bus
);
  localparam int unsigned W = 4 * DIGITS;
  localparam logic [3:0] LastIdx = 4'(DIGITS - 1);

`ifdef BCD_SUB_SIGN_MAG_EN
  typedef enum logic [1:0] {StIdle, StSub, StFix, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;
`endif

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, d_q, d_d;
  logic [3:0]     idx_q, idx_d;
  logic           borrow_q, borrow_d;
  logic           bout_q, bout_d;
  logic           err_q, err_d;
  logic           fix_phase;
  logic [3:0]     op_x, op_y, dig;
  logic [4:0]     t;
`ifdef BCD_SUB_SIGN_MAG_EN
  logic           neg_q, neg_d;
  assign fix_phase = (state_q == StFix);
`else
  assign fix_phase = 1'b0;
`endif

  // The FIX pass reuses the same digit slice as 0 - D.
  always_comb begin
    op_x = fix_phase ? 4'd0 : a_q[4*idx_q +: 4];
    op_y = fix_phase ? d_q[4*idx_q +: 4] : b_q[4*idx_q +: 4];
    t    = {1'b0, op_x} - {1'b0, op_y} - {4'd0, borrow_q};
    dig  = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    err_d    = err_q;
`ifdef BCD_SUB_SIGN_MAG_EN
    neg_d    = neg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.A;
          b_d      = bus.B;
          borrow_d = bus.Bin;
          d_d      = '0;
          idx_d    = 4'd0;
          bout_d   = 1'b0;
          err_d    = 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
          neg_d    = 1'b0;
`endif
          state_d  = StSub;
        end
      end
      StSub: begin
        d_d[4*idx_q +: 4] = dig;
        borrow_d = t[4];
        err_d    = err_q | (op_x > 4'd9) | (op_y > 4'd9);
        if (idx_q == LastIdx) begin
          idx_d   = 4'd0;
          bout_d  = t[4];
          state_d = StDone;
`ifdef BCD_SUB_SIGN_MAG_EN
          if (t[4]) begin
            borrow_d = 1'b0;
            neg_d    = 1'b1;
            state_d  = StFix;
          end
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`ifdef BCD_SUB_SIGN_MAG_EN
      StFix: begin
        d_d[4*idx_q +: 4] = dig;
        borrow_d = t[4];
        if (idx_q == LastIdx) begin
          idx_d   = 4'd0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= 4'd0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      d_q      <= d_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      err_q    <= err_d;
`ifdef BCD_SUB_SIGN_MAG_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.done  = (state_q == StDone);
  assign bus.D     = d_q;
  assign bus.Bout  = bout_q;
  assign bus.err   = err_q;
`ifdef BCD_SUB_SIGN_MAG_EN
  assign bus.neg   = neg_q;
`else
  assign bus.neg   = 1'b0;
`endif
endmodule

// File: doc/bcd_subtractor_serial.md
BCD_SUBTRACTOR_SERIAL -- requirements
Module: bcd_subtractor_serial

Interface
REQ-001 Parameter: DIGITS, 2, number of packed BCD digits per operand; legal values 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  request; accepted only when ready=1.
REQ-005 A  input  4*DIGITS  minuend, packed BCD, LSD in [3:0].
REQ-006 B  input  4*DIGITS  subtrahend, packed BCD.
REQ-007 Bin  input  1  borrow-in, subtracted from the least significant digit.
REQ-008 ready  output  1  high in IDLE only.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 D  output  4*DIGITS  difference, packed BCD, registered and held until the next accepted start.
REQ-011 Bout  output  1  borrow-out from the most significant digit.
REQ-012 neg  output  1  result negative; driven 0 when REQ-027 is compiled out.
REQ-013 err  output  1  at least one non-BCD digit (>9) was captured from A or B.

Function
REQ-014 FSM states: IDLE, SUB, FIX, DONE.
REQ-015 IDLE with start=1: capture A, B and Bin into internal registers, clear D/Bout/neg/err, set the digit index to 0, go to SUB.
REQ-016 SUB processes one digit per cycle, LSD first: t = a_i - b_i - borrow (5-bit signed); if t<0 then digit = t+10 and borrow = 1, else digit = t and borrow = 0.
REQ-017 After digit DIGITS-1: Bout = final borrow; go to FIX if REQ-027 is active and borrow=1, else go to DONE.
REQ-018 DONE lasts one cycle: done=1, then return to IDLE.
REQ-019 Latency: start accepted in cycle 0, digits processed in cycles 1..DIGITS, done in cycle DIGITS+1; with FIX the latency is 2*DIGITS+1.
REQ-020 start in any state other than IDLE is ignored; operand inputs are sampled only at acceptance.
REQ-021 A non-BCD digit sets err (sticky until next acceptance); arithmetic still follows REQ-016 unchanged.
REQ-022 done never coincides with ready; a start asserted in the cycle after done is accepted.
REQ-023 Only the captured operand registers are used after acceptance, so input changes mid-operation have no effect.

Reset
REQ-024 rst_n=0 at a clock edge forces IDLE, zeroes the digit index, D, Bout, neg, err and done, and sets ready=1.
REQ-025 Reset mid-operation aborts the operation with no done pulse; the first start after reset release is accepted normally.
REQ-026 No output is X after the first clock edge with rst_n=0.

Configuration
REQ-027 Macro BCD_SUB_SIGN_MAG_EN:
- Defined: FIX state serially computes D = 0 - D (borrow-in 0), one digit per cycle LSD first, reusing the REQ-016 digit logic; the result is the magnitude (10^DIGITS - raw). neg=1, Bout stays 1.
- Undefined: no FIX state; D is the raw ten's-complement result, neg is tied 0.

Verification
REQ-028 DIGITS=2, A=0x45, B=0x17, Bin=0 -> D=0x28, Bout=0, neg=0, done in cycle 3.
REQ-029 A=0x17, B=0x45, Bin=0 -> D=0x72, Bout=1 without the macro; with the macro D=0x28, neg=1, Bout=1, done in cycle 5.
REQ-030 A=0x00, B=0x00, Bin=1 -> D=0x99, Bout=1 without the macro; with the macro D=0x01, neg=1.
REQ-031 A=0x3A, B=0x01 -> D=0x39, Bout=0, err=1; the next start with valid digits clears err.
REQ-032 start is pulsed again in cycle 1 with different operands -> ignored, and the first result is unchanged.
REQ-033 rst_n=0 in cycle 2 -> no done pulse, all outputs 0, ready=1; the next operation completes correctly.
